// File: rtl/mpsoc_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_irq_pkg
// Brief    : Register map and field constants for the MPSoC interrupt controller.
// Revision : 1.0
// ============================================================================
package mpsoc_irq_pkg;

    localparam int MAX_IRQ = 16;
    localparam int DATA_W  = 16;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PENDING  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
    localparam logic [2:0] ADDR_VECTOR   = 3'd4;
    localparam logic [2:0] ADDR_SWTRIG   = 3'd5;
    localparam logic [2:0] ADDR_CTRL     = 3'd6;

    localparam int CTRL_GEN_BIT     = 0;
    localparam int VECTOR_VALID_BIT = 15;

endpackage
`default_nettype wire

// File: rtl/mpsoc_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_irq_prio_enc
// Brief    : Fixed-priority encoder, lowest set index wins; index is 0 when idle.
// Revision : 1.0
// ============================================================================
module mpsoc_irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [3:0]         o_index
);

    assign o_valid = |i_req;

    // Scanning downward lets the lowest requester overwrite any higher one.
    always_comb begin
        o_index = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_index = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mpsoc_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_irq_ctrl
// Brief    : Memory-mapped level/edge interrupt controller with mask, global
//            enable, priority vector and one registered CPU interrupt line.
// Revision : 1.0
// ============================================================================
module mpsoc_irq_ctrl
    import mpsoc_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [15:0]        readdata,
    output logic               irq
);

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge_sel;
    logic               r_gen;

    logic               w_wr_en;
    logic               w_wr_mask;
    logic               w_wr_pending;
    logic               w_wr_edge_sel;
    logic               w_wr_swtrig;
    logic               w_wr_ctrl;
    logic [NUM_IRQ-1:0] w_wdata;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [NUM_IRQ-1:0] w_active;
    logic               w_vec_valid;
    logic [3:0]         w_vec_idx;
    logic [DATA_W-1:0]  w_status16;
    logic [DATA_W-1:0]  w_mask16;
    logic [DATA_W-1:0]  w_pend16;
    logic [DATA_W-1:0]  w_edge16;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_unused;

    assign w_wr_en       = chipselect & ~write_n;
    assign w_wr_mask     = w_wr_en & (address == ADDR_MASK);
    assign w_wr_pending  = w_wr_en & (address == ADDR_PENDING);
    assign w_wr_edge_sel = w_wr_en & (address == ADDR_EDGE_SEL);
    assign w_wr_swtrig   = w_wr_en & (address == ADDR_SWTRIG);
    assign w_wr_ctrl     = w_wr_en & (address == ADDR_CTRL);
    assign w_wdata       = writedata[NUM_IRQ-1:0];
    assign w_active      = r_pending & r_mask;
    assign w_unused      = ^writedata;

    // Edge sources: set beats clear so a new event is never lost to a W1C.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
        assign w_set[gi]      = (irq_in[gi] & ~r_irq_prev[gi]) | (w_wr_swtrig & w_wdata[gi]);
        assign w_clr[gi]      = w_wr_pending & w_wdata[gi];
        assign w_pend_nxt[gi] = r_edge_sel[gi] ? (w_set[gi] | (r_pending[gi] & ~w_clr[gi]))
                                               : irq_in[gi];
    end

    mpsoc_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .i_req   (w_active),
        .o_valid (w_vec_valid),
        .o_index (w_vec_idx)
    );

    always_comb begin
        w_status16 = '0;
        w_mask16   = '0;
        w_pend16   = '0;
        w_edge16   = '0;
        w_status16[NUM_IRQ-1:0] = w_active;
        w_mask16[NUM_IRQ-1:0]   = r_mask;
        w_pend16[NUM_IRQ-1:0]   = r_pending;
        w_edge16[NUM_IRQ-1:0]   = r_edge_sel;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS:   w_rdata = w_status16;
            ADDR_MASK:     w_rdata = w_mask16;
            ADDR_PENDING:  w_rdata = w_pend16;
            ADDR_EDGE_SEL: w_rdata = w_edge16;
            ADDR_VECTOR: begin
                w_rdata[VECTOR_VALID_BIT] = w_vec_valid;
                w_rdata[3:0]              = w_vec_idx;
            end
            ADDR_CTRL:     w_rdata[CTRL_GEN_BIT] = r_gen;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_irq_prev <= '0;
            r_mask     <= '0;
            r_edge_sel <= '0;
            r_gen      <= 1'b0;
            irq        <= 1'b0;
            readdata   <= '0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_irq_prev <= irq_in;
            if (w_wr_mask)     r_mask     <= w_wdata;
            if (w_wr_edge_sel) r_edge_sel <= w_wdata;
            if (w_wr_ctrl)     r_gen      <= writedata[CTRL_GEN_BIT];
            irq      <= r_gen & (|w_active);
            readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_irq_ctrl.sv
`default_nettype none
// Testbench for mpsoc_irq_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a register-level behavioural model.
module tb_mpsoc_irq_ctrl;

    localparam int          N     = 8;
    localparam logic [15:0] NMASK = 16'h00FF;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [15:0]  writedata;
    logic [N-1:0] irq_in;
    logic [15:0]  readdata;
    logic         irq;

    mpsoc_irq_ctrl #(.NUM_IRQ(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_in     (irq_in),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state, kept as plain 16-bit words.
    logic [15:0]  m_pend, m_prev, m_mask, m_edge, m_rd;
    logic         m_gen, m_irq;
    logic [N-1:0] cur_in;
    logic [15:0]  d;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = '0; m_edge = '0;
        m_rd = '0; m_gen = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] pm, np, in16;
        logic        wr;
        if (!reset_n) begin
            model_reset();
            return;
        end
        in16 = 16'(irq_in);
        pm   = m_pend & m_mask;
        wr   = chipselect && !write_n;
        case (address)
            3'd0: m_rd = pm;
            3'd1: m_rd = m_mask;
            3'd2: m_rd = m_pend;
            3'd3: m_rd = m_edge;
            3'd4: begin
                m_rd = 16'h0000;
                for (int i = 0; i < 16; i++) begin
                    if (pm[i]) begin
                        m_rd = 16'h8000 + 16'(i);
                        break;
                    end
                end
            end
            3'd6: m_rd = {15'b0, m_gen};
            default: m_rd = 16'h0000;
        endcase
        np = '0;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if ((in16[i] && !m_prev[i]) || (wr && address == 3'd5 && writedata[i]))
                    np[i] = 1'b1;
                else if (wr && address == 3'd2 && writedata[i])
                    np[i] = 1'b0;
                else
                    np[i] = m_pend[i];
            end else begin
                np[i] = in16[i];
            end
        end
        m_irq  = m_gen && (pm != 0);
        m_pend = np;
        m_prev = in16;
        if (wr && address == 3'd1) m_mask = writedata & NMASK;
        if (wr && address == 3'd3) m_edge = writedata & NMASK;
        if (wr && address == 3'd6) m_gen  = writedata[0];
    endtask

    task automatic tick(input logic cs, input logic wn, input logic [2:0] a,
                        input logic [15:0] wd);
        chipselect = cs; write_n = wn; address = a; writedata = wd; irq_in = cur_in;
        @(posedge clk);
        model_step();
        #1;
        check("irq", {15'b0, irq}, {15'b0, m_irq});
        check("readdata", readdata, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 3'd7, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        tick(1'b1, 1'b0, a, v);
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        tick(1'b1, 1'b1, a, 16'h0);
        v = readdata;
    endtask

    // Called #1 after an edge: drops reset mid-cycle and checks its async effect.
    task automatic async_reset();
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_irq", {15'b0, irq}, 16'h0);
        check("async_rst_readdata", readdata, 16'h0);
        idle(1);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; cur_in = '0; irq_in = '0;
        model_reset();
        idle(2);
        reset_n = 1'b1;
        check("reset_irq", {15'b0, irq}, 16'h0);
        check("reset_readdata", readdata, 16'h0);

        // Level source on the timer line.
        wr(3'd1, 16'h0001);
        wr(3'd6, 16'h0001);
        cur_in = 8'h01;
        idle(1);
        check("t1_irq_lat0", {15'b0, irq}, 16'h0);
        idle(1);
        check("t1_irq_lat1", {15'b0, irq}, 16'h1);
        rd(3'd4, d); check("t1_vector", d, 16'h8000);
        cur_in = 8'h00;
        idle(2);
        check("t1_irq_drop", {15'b0, irq}, 16'h0);
        rd(3'd2, d); check("t1_pending", d, 16'h0000);

        // Edge latch and W1C.
        wr(3'd3, 16'h0004);
        wr(3'd1, 16'h0004);
        cur_in = 8'h04; idle(1);
        cur_in = 8'h00; idle(3);
        check("t2_irq_held", {15'b0, irq}, 16'h1);
        wr(3'd2, 16'h0004);
        idle(1);
        check("t2_irq_w1c", {15'b0, irq}, 16'h0);

        // Priority.
        wr(3'd3, 16'h0000);
        wr(3'd1, 16'h0028);
        cur_in = 8'h28; idle(2);
        rd(3'd4, d); check("t3_vec_3", d, 16'h8003);
        wr(3'd1, 16'h0020);
        rd(3'd4, d); check("t3_vec_5", d, 16'h8005);
        wr(3'd1, 16'h0000);
        rd(3'd4, d); check("t3_vec_none", d, 16'h0000);
        idle(1);
        check("t3_irq_off", {15'b0, irq}, 16'h0);

        // Set/clear collision.
        cur_in = 8'h00;
        wr(3'd3, 16'h0002);
        wr(3'd1, 16'h0002);
        idle(1);
        cur_in = 8'h02;
        wr(3'd2, 16'h0002);
        rd(3'd2, d); check("t4_collision", d, 16'h0002);

        // Software trigger.
        cur_in = 8'h00;
        wr(3'd3, 16'h0080);
        idle(1);
        wr(3'd5, 16'h00C0);
        rd(3'd2, d); check("t5_swtrig", d, 16'h0080);
        wr(3'd1, 16'h0080);
        rd(3'd0, d); check("t5_status", d, 16'h0080);
        wr(3'd1, 16'h0000);
        rd(3'd0, d); check("t5_status_masked", d, 16'h0000);

        // Global enable, then reset mid-interrupt.
        wr(3'd1, 16'h0080);
        wr(3'd6, 16'h0000);
        idle(1);
        check("t6_gen_off", {15'b0, irq}, 16'h0);
        rd(3'd4, d); check("t6_vec_gen_off", d, 16'h8007);
        wr(3'd6, 16'h0001);
        idle(1);
        check("t6_gen_on", {15'b0, irq}, 16'h1);
        cur_in = 8'h80; idle(1);
        async_reset();
        idle(1);
        wr(3'd3, 16'h0080);
        wr(3'd2, 16'h0080);
        idle(3);
        rd(3'd2, d); check("t6_no_retrigger", d, 16'h0000);
        cur_in = 8'h00; idle(1);
        cur_in = 8'h80; idle(1);
        rd(3'd2, d); check("t6_rearm", d, 16'h0080);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) cur_in = cur_in ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 799) == 0) begin
                async_reset();
            end else begin
                tick(1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
